// File: rtl/post_host_port.sv
// rtl/post_host_port.sv - host pin protocol responder for the Post machine core
//
// Decodes bytes sent by the off-chip host over a 4-phase strobe/ack handshake.
// The decoded bytes become program-memory writes, program-memory reads, status
// snapshots and run/stop control.
//
// Optional feature: define POST_HOSTPORT_TIMEOUT_EN to abort a stalled
// transaction after TIMEOUT_CYC idle cycles. The abort sets the sticky err flag.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   design select; 0 holds the FSM idle
//   data_i       in   [7:0] host byte
//   stb_i        in   host strobe, asynchronous to clk
//   ack_o        out  device acknowledge
//   rsp_o        out  [7:0] response byte (read data / status)
//   mem_addr_o   out  [ADDR_W-1:0] program-memory address
//   mem_wdata_o  out  [7:0] program-memory write data
//   mem_we_o     out  program-memory write strobe (1-cycle pulse)
//   mem_rdata_i  in   [7:0] program-memory read data
//   run_o        out  core run enable

module post_host_port #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        data_i,
  input  logic              stb_i,
  output logic              ack_o,
  output logic [7:0]        rsp_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              run_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_CTRL   = 2'b11;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_stb_sync;
  logic                    r_stb_d;
  logic                    r_ack;
  logic                    r_rd_pend;
  logic [1:0]              r_op;
  logic [ADDR_W-1:0]       r_addr;
  logic [7:0]              r_rsp;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [7:0]              r_mem_wdata;
  logic                    r_mem_we;
  logic                    r_run;
  logic                    r_err;

  logic w_stb_s;
  logic w_stb_rise;
  logic w_accept;
  logic w_timeout;
  logic w_do_status;
  logic w_load_op;
  logic w_load_addr;
  logic w_do_read;
  logic w_do_write;
  logic w_do_ctrl;

  assign w_stb_s    = r_stb_sync[SYNC_STAGES-1];
  assign w_stb_rise = w_stb_s & ~r_stb_d;
  // A byte is taken only on a fresh strobe edge while the previous ack is
  // fully retired and no read capture is still pending.
  assign w_accept   = ena & w_stb_rise & ~r_ack & ~r_rd_pend;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (!ena || w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          case (data_i[7:6])
            OP_WRITE, OP_READ: w_state_nxt = S_ADDR;
            OP_CTRL:           w_state_nxt = S_DATA;
            default:           w_state_nxt = S_IDLE;
          endcase
        end
        S_ADDR:  w_state_nxt = (r_op == OP_READ) ? S_IDLE : S_DATA;
        S_DATA:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: which action the accepted byte triggers
  always_comb begin
    w_do_status = 1'b0;
    w_load_op   = 1'b0;
    w_load_addr = 1'b0;
    w_do_read   = 1'b0;
    w_do_write  = 1'b0;
    w_do_ctrl   = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (data_i[7:6] == OP_STATUS) w_do_status = 1'b1;
          else                          w_load_op   = 1'b1;
        end
        S_ADDR: begin
          if (r_op == OP_READ) w_do_read   = 1'b1;
          else                 w_load_addr = 1'b1;
        end
        S_DATA: begin
          if (r_op == OP_WRITE) w_do_write = 1'b1;
          else                  w_do_ctrl  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Synchronizer and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb_sync  <= '0;
      r_stb_d     <= 1'b0;
      r_ack       <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_op        <= OP_STATUS;
      r_addr      <= '0;
      r_rsp       <= 8'h00;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_run       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], stb_i};
      r_stb_d    <= w_stb_s;
      r_mem_we   <= w_do_write;

      if (!ena) begin
        r_ack     <= 1'b0;
        r_rd_pend <= 1'b0;
      end else if (r_rd_pend || (w_accept && !w_do_read)) begin
        r_ack <= 1'b1;
      end else if (!w_stb_s) begin
        r_ack <= 1'b0;
      end

      if (ena) begin
        r_rd_pend <= w_do_read;
      end

      // Read data is captured one cycle after the address is presented, and
      // the ack is held back until that same edge so rsp is valid with ack.
      if (r_rd_pend && ena) begin
        r_rsp <= mem_rdata_i;
      end

      if (w_load_op)   r_op   <= data_i[7:6];
      if (w_load_addr) r_addr <= data_i[ADDR_W-1:0];

      if (w_do_read) begin
        r_mem_addr <= data_i[ADDR_W-1:0];
      end

      if (w_do_write) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= data_i;
      end

      if (w_do_status) begin
        r_rsp <= {r_run, r_err, 4'b0000, r_state};
      end

      if (w_do_ctrl) begin
        r_run <= data_i[0] & ~data_i[1];
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (w_do_status || (w_do_ctrl && data_i[1])) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef POST_HOSTPORT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_idle;

  // Counts only while the host owes us the next strobe mid-transaction.
  assign w_to_idle = ena && (r_state != S_IDLE) && !r_ack && !w_stb_s;
  assign w_timeout = w_to_idle && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!ena || (r_state == S_IDLE) || w_accept || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_to_idle) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_timeout            = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  assign ack_o       = r_ack;
  assign rsp_o       = r_rsp;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_we_o    = r_mem_we;
  assign run_o       = r_run;

endmodule
